// File: rtl/instruction_fetch_issue.sv
// Fetch/issue stage of the 8-bit MIPS pipeline: owns the PC, reads the async
// instruction ROM and issues a registered 24-bit word with JMP/LD/COND_J handling.
module instruction_fetch_issue #(
    parameter int                 PC_W     = 8,
    parameter logic [PC_W-1:0]    RESET_PC = {PC_W{1'b0}},
    parameter logic [23:0]        NOP_WORD = 24'h000000
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] im_addr,
    input  logic [23:0]     im_data,
    input  logic            stall,
    input  logic            cj_resolve,
    input  logic            cj_taken,
    output logic [23:0]     ins,
    output logic [PC_W-1:0] pc_dec,
    output logic            cj_pending
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LD_REPLAY = 2'd1,
        CJ_WAIT   = 2'd2
    } state_t;

    localparam logic [4:0] OP_JMP = 5'b11000;
    localparam logic [4:0] OP_LD  = 5'b10100;

    function automatic logic is_jmp(input logic [23:0] w);
        return (w[23:19] == OP_JMP);
    endfunction

    function automatic logic is_ld(input logic [23:0] w);
        return (w[23:19] == OP_LD);
    endfunction

    function automatic logic is_condj(input logic [23:0] w);
        return (w[23:21] == 3'b111);
    endfunction

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [23:0]     ins_q, ins_d;
    logic [PC_W-1:0] pc_dec_q, pc_dec_d;
    logic [PC_W-1:0] cj_target_q, cj_target_d;
    logic            cj_pending_q, cj_pending_d;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] tgt_s;

    assign pc_inc_s   = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign tgt_s      = PC_W'(im_data[18:11]);
    assign im_addr    = pc_q;
    assign ins        = ins_q;
    assign pc_dec     = pc_dec_q;
    assign cj_pending = cj_pending_q;

    // Next-state and issue logic; stall freezes everything.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        pc_dec_d    = pc_dec_q;
        cj_target_d = cj_target_q;
        if (!stall) begin
            case (state_q)
                RUN: begin
                    ins_d    = im_data;
                    pc_dec_d = pc_q;
                    if (is_jmp(im_data)) begin
                        pc_d = tgt_s;
                    end else if (is_ld(im_data)) begin
                        pc_d    = pc_inc_s;
                        state_d = LD_REPLAY;
                    end else if (is_condj(im_data)) begin
                        pc_d        = pc_inc_s;
                        cj_target_d = tgt_s;
                        state_d     = CJ_WAIT;
                    end else begin
                        pc_d = pc_inc_s;
                    end
                end
                // The replayed copy is issued undecoded; its second copy is decoded in RUN.
                LD_REPLAY: begin
                    ins_d    = im_data;
                    pc_dec_d = pc_q;
                    state_d  = RUN;
                end
                CJ_WAIT: begin
                    ins_d    = NOP_WORD;
                    pc_dec_d = {PC_W{1'b0}};
                    if (cj_resolve) begin
                        state_d = RUN;
                        if (cj_taken) begin
                            pc_d = cj_target_q;
                        end else begin
                            pc_d = pc_q;
                        end
                    end else begin
                        state_d = CJ_WAIT;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign cj_pending_d = (state_d == CJ_WAIT);

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ins_q        <= 24'h000000;
            pc_dec_q     <= {PC_W{1'b0}};
            cj_target_q  <= {PC_W{1'b0}};
            cj_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ins_q        <= ins_d;
            pc_dec_q     <= pc_dec_d;
            cj_target_q  <= cj_target_d;
            cj_pending_q <= cj_pending_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_issue.sv
// Directed, table-driven bench for instruction_fetch_issue with a behavioural ROM.
module tb_instruction_fetch_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  im_addr;
    logic [23:0] im_data;
    logic        stall = 1'b0;
    logic        cj_resolve = 1'b0;
    logic        cj_taken = 1'b0;
    logic [23:0] ins;
    logic [7:0]  pc_dec;
    logic        cj_pending;

    logic [23:0] rom [0:255];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst, stl, res, tak;
        logic [23:0] e_ins;
        logic [7:0]  e_pcd, e_addr;
        logic        e_pend;
    } vec_t;
    vec_t vecs[$];

    assign im_data = rom[im_addr];

    instruction_fetch_issue #(.PC_W(8), .RESET_PC(8'h00), .NOP_WORD(24'h000000)) dut (
        .clk(clk), .reset(reset), .im_addr(im_addr), .im_data(im_data),
        .stall(stall), .cj_resolve(cj_resolve), .cj_taken(cj_taken),
        .ins(ins), .pc_dec(pc_dec), .cj_pending(cj_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic [4:0] op, input logic [7:0] tgt, input logic [10:0] lo);
        return {op, tgt, lo};
    endfunction

    function automatic vec_t mkv(input logic rst, stl, res, tak, input logic [23:0] ei,
                                 input logic [7:0] epcd, eaddr, input logic epend);
        vec_t v;
        v.rst = rst; v.stl = stl; v.res = res; v.tak = tak;
        v.e_ins = ei; v.e_pcd = epcd; v.e_addr = eaddr; v.e_pend = epend;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        reset = v.rst; stall = v.stl; cj_resolve = v.res; cj_taken = v.tak;
        @(posedge clk);
        #1;
        n_tests++;
        if (ins !== v.e_ins || pc_dec !== v.e_pcd || im_addr !== v.e_addr || cj_pending !== v.e_pend) begin
            n_fail++;
            $display("FAIL %s: got ins=%h pc_dec=%h im_addr=%h cj_pending=%b, want ins=%h pc_dec=%h im_addr=%h cj_pending=%b",
                     name, ins, pc_dec, im_addr, cj_pending, v.e_ins, v.e_pcd, v.e_addr, v.e_pend);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = mk(5'b00001, 8'h00, 11'(i));
        rom[8'h02] = mk(5'b11000, 8'h20, 11'h002);   // JMP 0x20
        rom[8'h21] = mk(5'b10100, 8'h00, 11'h021);   // LD
        rom[8'h24] = mk(5'b11101, 8'h40, 11'h024);   // COND_J 0x40
        rom[8'h41] = mk(5'b11110, 8'h60, 11'h041);   // COND_J 0x60
        rom[8'h43] = mk(5'b11000, 8'hFF, 11'h043);   // JMP 0xFF

        //              rst   stl   res   tak   ins          pc_dec addr  pend
        vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h00], 8'h00, 8'h01, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h01], 8'h01, 8'h02, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h02], 8'h02, 8'h20, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h20], 8'h20, 8'h21, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h21], 8'h21, 8'h22, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h22], 8'h22, 8'h22, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h22], 8'h22, 8'h23, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h23], 8'h23, 8'h24, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h24], 8'h24, 8'h25, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 8'h00, 8'h25, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 8'h00, 8'h25, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 1'b1, 24'h000000, 8'h00, 8'h40, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h40], 8'h40, 8'h41, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h41], 8'h41, 8'h42, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 8'h00, 8'h42, 1'b1));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 8'h00, 8'h42, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 1'b1, rom[8'h42], 8'h42, 8'h43, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h43], 8'h43, 8'hFF, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'hFF], 8'hFF, 8'h00, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h00], 8'h00, 8'h01, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b1, 1'b0, 1'b0, rom[8'h00], 8'h00, 8'h01, 1'b0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h01], 8'h01, 8'h02, 1'b0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

        // Stall held for two cycles mid-CJ_WAIT while resolve is asserted.
        rom[8'h00] = mk(5'b11111, 8'h40, 11'h000);
        step(mkv(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 8'h00, 8'h00, 1'b0), "cjst_rst");
        step(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h00], 8'h00, 8'h01, 1'b1), "cjst_issue");
        step(mkv(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 8'h00, 8'h01, 1'b1), "cjst_wait");
        step(mkv(1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 8'h00, 8'h01, 1'b1), "cjst_stall1");
        step(mkv(1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 8'h00, 8'h01, 1'b1), "cjst_stall2");
        step(mkv(1'b0, 1'b0, 1'b1, 1'b1, 24'h000000, 8'h00, 8'h40, 1'b0), "cjst_resolve");
        step(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h40], 8'h40, 8'h41, 1'b0), "cjst_target");

        // Reset during CJ_WAIT discards the pending jump.
        step(mkv(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 8'h00, 8'h00, 1'b0), "cjrst_rst0");
        step(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h00], 8'h00, 8'h01, 1'b1), "cjrst_issue");
        step(mkv(1'b1, 1'b0, 1'b1, 1'b1, 24'h000000, 8'h00, 8'h00, 1'b0), "cjrst_rst");
        step(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h00], 8'h00, 8'h01, 1'b1), "cjrst_run");

        // Reset during LD_REPLAY returns to RUN.
        rom[8'h00] = mk(5'b10100, 8'h00, 11'h000);
        step(mkv(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 8'h00, 8'h00, 1'b0), "ldrst_rst0");
        step(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h00], 8'h00, 8'h01, 1'b0), "ldrst_issue");
        step(mkv(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 8'h00, 8'h00, 1'b0), "ldrst_rst");
        step(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h00], 8'h00, 8'h01, 1'b0), "ldrst_run");
        step(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h01], 8'h01, 8'h01, 1'b0), "ldrst_replay");
        step(mkv(1'b0, 1'b0, 1'b0, 1'b0, rom[8'h01], 8'h01, 8'h02, 1'b0), "ldrst_second");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
